// File: rtl/mem_responder.sv
// Slave-side word memory for the req/ack/resp bus: one request at a time, registered outputs, configurable wait states.
// Optional build macro MEM_RESPONDER_RAND_DELAY_EN adds LFSR-driven extra ack wait states.
module mem_responder #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int ACK_DELAY  = 1,
  parameter int RESP_DELAY = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              cmd_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic              resp_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_MAX = (ACK_DELAY + 3 > RESP_DELAY) ? ACK_DELAY + 3 : RESP_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_ACK, S_ACK, S_RD_WAIT, S_RESP, S_RELEASE
  } state_t;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_ack_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_cmd;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ack, r_resp, r_busy;
  logic              w_ack_next, w_resp_next, w_busy_next;
  logic              w_accept;
  logic              w_unused_addr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  assign w_accept      = (r_state == S_IDLE) && req_i;
  // Upper address bits alias onto the same words.
  assign w_unused_addr = ^addr_i;

`ifdef MEM_RESPONDER_RAND_DELAY_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_lfsr <= 16'hACE1;
    else if (w_accept)
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_ack_cnt = CNT_W'(ACK_DELAY) + CNT_W'(r_lfsr[1:0]);
`else
  assign w_ack_cnt = CNT_W'(ACK_DELAY);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (req_i) w_state_next = (w_ack_cnt == '0) ? S_ACK : S_WAIT_ACK;
      S_WAIT_ACK: if (r_cnt <= CNT_W'(1)) w_state_next = S_ACK;
      S_ACK:      if (r_cmd) w_state_next = S_RELEASE;
                  else       w_state_next = (RESP_DELAY == 1) ? S_RESP : S_RD_WAIT;
      S_RD_WAIT:  if (r_cnt <= CNT_W'(1)) w_state_next = S_RESP;
      S_RESP:     w_state_next = S_RELEASE;
      S_RELEASE:  if (!req_i) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the state being entered.
  always_comb begin
    w_ack_next  = (w_state_next == S_ACK);
    w_resp_next = (w_state_next == S_RESP);
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ack   <= 1'b0;
      r_resp  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack  <= w_ack_next;
      r_resp <= w_resp_next;
      r_busy <= w_busy_next;
      if (w_resp_next)
        r_rdata <= r_hold;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_cmd   <= 1'b0;
      r_wdata <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_i) begin
          r_cnt   <= w_ack_cnt;
          r_idx   <= addr_i[IDX_W-1:0];
          r_cmd   <= cmd_i;
          r_wdata <= wdata_i;
        end
        S_WAIT_ACK, S_RD_WAIT: if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        S_ACK: begin
          r_cnt <= CNT_W'(RESP_DELAY - 1);
          if (!r_cmd)
            r_hold <= r_mem[r_idx];
        end
        default: ;
      endcase
    end
  end

  // Write commits in the ACK cycle, so any later capture sees the new word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (r_state == S_ACK && r_cmd) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign ack_o   = r_ack;
  assign resp_o  = r_resp;
  assign busy_o  = r_busy;
  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic against a word-array model.
module tb_mem_responder;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 16;
  localparam int ACK_DELAY  = 1;
  localparam int RESP_DELAY = 2;
  localparam int ACK_CYC    = 1 + ACK_DELAY;
  localparam int RESP_CYC   = 1 + ACK_DELAY + RESP_DELAY;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              req_i = 1'b0;
  logic [ADDR_W-1:0] addr_i = '0;
  logic              cmd_i = 1'b0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic              ack_o, resp_o, busy_o;
  logic [DATA_W-1:0] rdata_o;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] ref_mem [DEPTH];

  mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .ACK_DELAY(ACK_DELAY), .RESP_DELAY(RESP_DELAY)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .addr_i(addr_i),
    .cmd_i(cmd_i), .wdata_i(wdata_i), .ack_o(ack_o), .resp_o(resp_o),
    .rdata_o(rdata_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'(a % DEPTH);
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Drives one request and records what the bus did; cycle k is k clocks after the capture edge.
  task automatic run_txn(input logic cmd, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                         input int hold, output int ack_cyc, output int n_ack, output int resp_cyc,
                         output int n_resp, output logic [DATA_W-1:0] rdata, output int overlap,
                         output int idle_ok);
    ack_cyc = -1; n_ack = 0; resp_cyc = -1; n_resp = 0; rdata = '0; overlap = 0; idle_ok = 0;
    @(negedge clk_i);
    req_i = 1'b1; cmd_i = cmd; addr_i = addr; wdata_i = wdata;
    for (int k = 1; k <= RESP_CYC + hold + 4; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (k == 1) begin
        addr_i = $urandom; wdata_i = $urandom; cmd_i = ~cmd;
      end
      if (ack_o) begin n_ack++; if (ack_cyc < 0) ack_cyc = k; end
      if (resp_o) begin n_resp++; if (resp_cyc < 0) begin resp_cyc = k; rdata = rdata_o; end end
      if (ack_o && resp_o) overlap = 1;
      if (ack_cyc >= 0 && k == ack_cyc + hold) req_i = 1'b0;
    end
    req_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!busy_o) begin idle_ok = 1; break; end
      @(posedge clk_i);
      @(negedge clk_i);
    end
    $display("txn cmd=%0d addr=%h wdata=%h hold=%0d ack@%0d(x%0d) resp@%0d(x%0d) rdata=%h",
             cmd, addr, wdata, hold, ack_cyc, n_ack, resp_cyc, n_resp, rdata);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    ref_clear();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({ack_o, resp_o, busy_o} !== 3'b000 || rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b resp=%b busy=%b rdata=%h required all 0", ack_o, resp_o, busy_o, rdata_o);
    end
    rst_n_i = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_basic_read();
    int ac, na, rc, nr, ov, il; logic [DATA_W-1:0] rd;
    run_txn(1'b0, 32'h3, '0, 0, ac, na, rc, nr, rd, ov, il);
    checks++; if (ac !== ACK_CYC || na !== 1) begin errors++; $display("FAIL read3_ack: got cycle %0d count %0d required cycle %0d count 1", ac, na, ACK_CYC); end
    checks++; if (rc !== RESP_CYC || nr !== 1) begin errors++; $display("FAIL read3_resp: got cycle %0d count %0d required cycle %0d count 1", rc, nr, RESP_CYC); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL read3_data: got %h required 0", rd); end
    checks++; if (il !== 1) begin errors++; $display("FAIL read3_idle: busy_o stayed high after req dropped"); end
  endtask

  task automatic test_write_read();
    int ac, na, rc, nr, ov, il; logic [DATA_W-1:0] rd;
    run_txn(1'b1, 32'h5, 32'hDEADBEEF, 0, ac, na, rc, nr, rd, ov, il);
    ref_mem[5] = 32'hDEADBEEF;
    checks++; if (ac !== ACK_CYC || na !== 1) begin errors++; $display("FAIL write5_ack: got cycle %0d count %0d required cycle %0d count 1", ac, na, ACK_CYC); end
    checks++; if (nr !== 0) begin errors++; $display("FAIL write5_noresp: got %0d resp pulses required 0", nr); end
    run_txn(1'b0, 32'h5, '0, 0, ac, na, rc, nr, rd, ov, il);
    checks++; if (rc !== RESP_CYC || rd !== ref_mem[5]) begin errors++; $display("FAIL read5: got cycle %0d data %h required cycle %0d data %h", rc, rd, RESP_CYC, ref_mem[5]); end
  endtask

  task automatic test_alias();
    int ac, na, rc, nr, ov, il; logic [DATA_W-1:0] rd;
    run_txn(1'b1, 32'h15, 32'h00001234, 0, ac, na, rc, nr, rd, ov, il);
    ref_mem[idx_of(32'h15)] = 32'h00001234;
    run_txn(1'b0, 32'h5, '0, 0, ac, na, rc, nr, rd, ov, il);
    checks++; if (rd !== 32'h00001234 || nr !== 1) begin errors++; $display("FAIL alias_read: got %h (resp x%0d) required 00001234", rd, nr); end
  endtask

  task automatic test_hold_req();
    int ac, na, rc, nr, ov, il; logic [DATA_W-1:0] rd;
    run_txn(1'b1, 32'h9, 32'h0BADF00D, 5, ac, na, rc, nr, rd, ov, il);
    ref_mem[9] = 32'h0BADF00D;
    checks++; if (na !== 1) begin errors++; $display("FAIL hold_single_ack: got %0d acks required 1", na); end
    run_txn(1'b0, 32'h9, '0, 0, ac, na, rc, nr, rd, ov, il);
    checks++; if (ac !== ACK_CYC || rd !== 32'h0BADF00D) begin errors++; $display("FAIL hold_reraise: got ack cycle %0d data %h required cycle %0d data 0badf00d", ac, rd, ACK_CYC); end
  endtask

  task automatic test_random();
    int ac, na, rc, nr, ov, il; logic [DATA_W-1:0] rd, exp_d;
    logic cmd; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] wd; int hold;
    for (int n = 0; n < 40; n++) begin
      cmd = 1'($urandom_range(0, 1)); a = $urandom; wd = $urandom; hold = $urandom_range(0, 2);
      exp_d = ref_mem[idx_of(a)];
      run_txn(cmd, a, wd, hold, ac, na, rc, nr, rd, ov, il);
      if (cmd) ref_mem[idx_of(a)] = wd;
      checks++;
      if (ac !== ACK_CYC || na !== 1 || ov !== 0 || il !== 1) begin
        errors++; $display("FAIL rand%0d_ack: got cycle %0d count %0d overlap %0d idle %0d required cycle %0d count 1 overlap 0 idle 1", n, ac, na, ov, il, ACK_CYC);
      end
      checks++;
      if (cmd && nr !== 0) begin
        errors++; $display("FAIL rand%0d_wr_resp: got %0d resp pulses required 0", n, nr);
      end else if (!cmd && (rc !== RESP_CYC || nr !== 1 || rd !== exp_d)) begin
        errors++; $display("FAIL rand%0d_rd: got cycle %0d count %0d data %h required cycle %0d count 1 data %h", n, rc, nr, rd, RESP_CYC, exp_d);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    int ac, na, rc, nr, ov, il, seen; logic [DATA_W-1:0] rd;
    run_txn(1'b1, 32'h5, 32'hDEADBEEF, 0, ac, na, rc, nr, rd, ov, il);
    run_txn(1'b0, 32'h5, '0, 0, ac, na, rc, nr, rd, ov, il);
    @(negedge clk_i);
    req_i = 1'b1; cmd_i = 1'b0; addr_i = 32'h5;
    repeat (3) begin @(posedge clk_i); @(negedge clk_i); end
    req_i = 1'b0;
    checks++; if (busy_o !== 1'b1 || rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL rst_mid_pre: got busy=%b rdata=%h required busy 1 rdata deadbeef", busy_o, rdata_o); end
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ack_o, resp_o, busy_o} !== 3'b000 || rdata_o !== '0) begin
      errors++; $display("FAIL rst_mid_async: got ack=%b resp=%b busy=%b rdata=%h required all 0", ack_o, resp_o, busy_o, rdata_o);
    end
    ref_clear();
    seen = 0;
    repeat (2) begin @(posedge clk_i); @(negedge clk_i); if (resp_o) seen = 1; end
    rst_n_i = 1'b1;
    repeat (4) begin @(posedge clk_i); @(negedge clk_i); if (resp_o) seen = 1; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_noresp: got resp pulse required none"); end
    $display("txn reset during read wait state");
    run_txn(1'b0, 32'h5, '0, 0, ac, na, rc, nr, rd, ov, il);
    checks++; if (rd !== '0 || nr !== 1) begin errors++; $display("FAIL rst_mid_cleared: got %h (resp x%0d) required 0", rd, nr); end
  endtask

  // Two masters contend; a round-robin pointer decides who is served first.
  task automatic test_arbiter_pair();
    int ac, na, rc, nr, ov, il, rr, m; logic [DATA_W-1:0] rd, wv, exp_rd;
    logic [DATA_W-1:0] wvals [2];
    wvals[0] = 32'hA5A5A5A5; wvals[1] = 32'h5A5A5A5A;
    rr = $urandom_range(0, 1);
    for (int round = 0; round < 2; round++) begin
      wv = wvals[round];
      exp_rd = (rr == 0) ? wv : ref_mem[2];
      for (int g = 0; g < 2; g++) begin
        m = (rr + g) % 2;
        if (m == 0) begin
          run_txn(1'b1, 32'h2, wv, 0, ac, na, rc, nr, rd, ov, il);
          ref_mem[2] = wv;
        end else begin
          run_txn(1'b0, 32'h2, '0, 0, ac, na, rc, nr, rd, ov, il);
          checks++; if (rd !== exp_rd) begin errors++; $display("FAIL arb_r%0d_read: got %h required %h", round, rd, exp_rd); end
        end
        checks++; if (na !== 1) begin errors++; $display("FAIL arb_r%0d_m%0d_ack: got %0d acks required 1", round, m, na); end
      end
      rr = 1 - rr;
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_alias();
    test_hold_req();
    test_random();
    test_reset_mid_read();
    test_arbiter_pair();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end
endmodule
